// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and helpers for the MIPS instruction-fetch front end.
package fetch_pc_unit_pkg;

    typedef enum logic [1:0] {
        REDIR_BRANCH = 2'b00,
        REDIR_JUMP   = 2'b01,
        REDIR_JR     = 2'b10,
        REDIR_RSVD   = 2'b11
    } redir_kind_e;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'b00,
        ST_FETCH  = 2'b01,
        ST_STALL  = 2'b10,
        ST_HALTED = 2'b11
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HALT_INST = 32'h0000_000C;
    localparam logic [31:0] PC_STEP           = 32'd4;

    function automatic logic [31:0] sign_ext16(input logic [15:0] value);
        return {{16{value[15]}}, value};
    endfunction

    function automatic logic [31:0] shl2(input logic [31:0] value);
        return {value[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_unit_target_calc.sv
// Combinational redirect target selection using MIPS word-address arithmetic.
module target_calc
    import fetch_pc_unit_pkg::*;
(
    input  logic [1:0]  kind,
    input  logic [31:0] pc_plus4,
    input  logic [15:0] imm16,
    input  logic [25:0] index26,
    input  logic [31:0] reg_value,
    output logic [31:0] target,
    output logic        target_ok
);

    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_target;

    assign branch_target = pc_plus4 + shl2(sign_ext16(imm16));
    assign jump_target   = {pc_plus4[31:28], index26, 2'b00};
    // Register targets are forced word-aligned rather than trapping.
    assign jr_target     = {reg_value[31:2], 2'b00};

    always_comb begin
        target    = branch_target;
        target_ok = 1'b1;
        case (redir_kind_e'(kind))
            REDIR_BRANCH: target = branch_target;
            REDIR_JUMP:   target = jump_target;
            REDIR_JR:     target = jr_target;
            default:      target_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch front end: owns the PC, runs the imem handshake and holds the decode register.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          BOOT_CYCLES = 2,
    parameter logic [31:0] HALT_INST   = DEFAULT_HALT_INST
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    input  logic        id_stall,
    input  logic        redir_valid,
    input  logic [1:0]  redir_kind,
    input  logic [31:0] redir_pc_plus4,
    input  logic [15:0] redir_imm16,
    input  logic [25:0] redir_index26,
    input  logic [31:0] redir_reg,
    output logic        halted,
    output logic [31:0] fetch_count
);

    localparam fetch_state_e RESET_STATE = (BOOT_CYCLES == 0) ? ST_FETCH : ST_BOOT;
    localparam logic [31:0]  BOOT_LAST   = (BOOT_CYCLES == 0) ? 32'd0 : 32'(BOOT_CYCLES - 1);

    fetch_state_e state;
    fetch_state_e state_next;
    logic [31:0]  pc;
    logic [31:0]  pc_seq;
    logic [31:0]  boot_cnt;
    logic [31:0]  redir_target;
    logic         redir_ok;
    logic         redir_take;
    logic         accept;
    logic         free;
    logic         fetching;
    logic         capture;

    target_calc u_target_calc (
        .kind      (redir_kind),
        .pc_plus4  (redir_pc_plus4),
        .imm16     (redir_imm16),
        .index26   (redir_index26),
        .reg_value (redir_reg),
        .target    (redir_target),
        .target_ok (redir_ok)
    );

    assign accept     = if_valid & ~id_stall;
    assign free       = ~if_valid | ~id_stall;
    assign fetching   = (state == ST_FETCH) || (state == ST_STALL);
    // Any redirect strobe suppresses the request so no stale word is captured.
    assign imem_req   = ~rst & fetching & free & ~redir_valid;
    assign imem_addr  = pc;
    assign capture    = imem_req & imem_ready;
    assign redir_take = redir_valid & redir_ok & (state != ST_BOOT);
    assign halted     = (state == ST_HALTED);
    assign pc_seq     = pc + PC_STEP;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RESET_STATE;
            boot_cnt <= 32'd0;
        end else begin
            state <= state_next;
            if (state == ST_BOOT) begin
                boot_cnt <= boot_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_BOOT: begin
                if (boot_cnt == BOOT_LAST) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH, ST_STALL: begin
                if (capture && (imem_rdata == HALT_INST)) begin
                    state_next = ST_HALTED;
                end else if (if_valid && id_stall) begin
                    state_next = ST_STALL;
                end else begin
                    state_next = ST_FETCH;
                end
            end
            ST_HALTED: state_next = ST_HALTED;
            default:   state_next = RESET_STATE;
        endcase
        if (redir_take) begin
            state_next = ST_FETCH;
        end
    end

    // A redirect flushes the decode register even when decode is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            if_valid    <= 1'b0;
            if_inst     <= 32'd0;
            if_pc       <= 32'd0;
            if_pc_plus4 <= 32'd0;
            fetch_count <= 32'd0;
        end else begin
            if (accept) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (redir_take) begin
                pc       <= redir_target;
                if_valid <= 1'b0;
            end else if (capture) begin
                if_inst     <= imem_rdata;
                if_pc       <= pc;
                if_pc_plus4 <= pc_seq;
                if_valid    <= 1'b1;
                pc          <= pc_seq;
            end else if (accept) begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit with an address-derived memory model.
module tb_fetch_pc_unit;
    import fetch_pc_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        id_stall = 1'b0;
    logic        redir_valid = 1'b0;
    logic [1:0]  redir_kind = 2'b00;
    logic [31:0] redir_pc_plus4 = 32'd0;
    logic [15:0] redir_imm16 = 16'd0;
    logic [25:0] redir_index26 = 26'd0;
    logic [31:0] redir_reg = 32'd0;
    logic        halted;
    logic [31:0] fetch_count;
    logic        halt_en = 1'b0;
    int          checks = 0;
    int          errors = 0;

    // Every word encodes its own address, except the halt word at 0x10 when enabled.
    assign imem_rdata = (halt_en && imem_addr == 32'h10) ? 32'h0000_000C : (32'h1000_0000 | imem_addr);

    fetch_pc_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .id_stall       (id_stall),
        .redir_valid    (redir_valid),
        .redir_kind     (redir_kind),
        .redir_pc_plus4 (redir_pc_plus4),
        .redir_imm16    (redir_imm16),
        .redir_index26  (redir_index26),
        .redir_reg      (redir_reg),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before completion");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one tick into the first cycle after reset.
    task automatic do_reset();
        rst = 1'b1;
        redir_valid = 1'b0;
        id_stall = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        imem_ready = 1'b1;
        rst = 1'b1;
        cyc();
        cyc();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %0h want 0", imem_req); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0h want 0", if_valid); end
        checks++; if (fetch_count !== 32'd0) begin errors++; $display("[TB] FAIL reset_count got %h want 0", fetch_count); end
        checks++; if (imem_addr !== 32'd0) begin errors++; $display("[TB] FAIL reset_addr got %h want 0", imem_addr); end
        checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted got %0h want 0", halted); end
        rst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL boot_c1_req got %0h want 0", imem_req); end
        cyc();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL boot_c2_req got %0h want 0", imem_req); end
        cyc();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL boot_c3_req got %0h want 1", imem_req); end
        checks++; if (imem_addr !== 32'd0) begin errors++; $display("[TB] FAIL boot_c3_addr got %h want 0", imem_addr); end
    endtask

    task automatic test_sequential();
        imem_ready = 1'b1;
        do_reset();
        cyc();
        cyc();
        cyc();
        checks++; if (if_valid !== 1'b1) begin errors++; $display("[TB] FAIL seq_valid got %0h want 1", if_valid); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("[TB] FAIL seq_pc0 got %h want 0", if_pc); end
        checks++; if (if_inst !== 32'h1000_0000) begin errors++; $display("[TB] FAIL seq_inst0 got %h want 10000000", if_inst); end
        checks++; if (if_pc_plus4 !== 32'h4) begin errors++; $display("[TB] FAIL seq_pc4_0 got %h want 4", if_pc_plus4); end
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("[TB] FAIL seq_addr got %h want 4", imem_addr); end
        cyc();
        checks++; if (if_pc !== 32'h4) begin errors++; $display("[TB] FAIL seq_pc1 got %h want 4", if_pc); end
        checks++; if (fetch_count !== 32'd1) begin errors++; $display("[TB] FAIL seq_count1 got %0d want 1", fetch_count); end
        cyc();
        checks++; if (if_pc !== 32'h8) begin errors++; $display("[TB] FAIL seq_pc2 got %h want 8", if_pc); end
        cyc();
        checks++; if (fetch_count !== 32'd3) begin errors++; $display("[TB] FAIL seq_count3 got %0d want 3", fetch_count); end
        checks++; if (if_pc !== 32'hC) begin errors++; $display("[TB] FAIL seq_pc3 got %h want c", if_pc); end
    endtask

    task automatic test_slow_memory();
        imem_ready = 1'b0;
        do_reset();
        cyc();
        cyc();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL slow_req got %0h want 1", imem_req); end
        cyc();
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL slow_addr_hold got %h want 0", imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL slow_valid_wait got %0h want 0", if_valid); end
        cyc();
        imem_ready = 1'b1;
        cyc();
        imem_ready = 1'b0;
        checks++; if (if_pc !== 32'h0 || if_valid !== 1'b1) begin errors++; $display("[TB] FAIL slow_first got pc %h v %0h want 0 1", if_pc, if_valid); end
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("[TB] FAIL slow_addr_next got %h want 4", imem_addr); end
        cyc();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL slow_gap_valid got %0h want 0", if_valid); end
        checks++; if (fetch_count !== 32'd1) begin errors++; $display("[TB] FAIL slow_count1 got %0d want 1", fetch_count); end
        cyc();
        imem_ready = 1'b1;
        cyc();
        imem_ready = 1'b0;
        checks++; if (if_pc !== 32'h4 || if_inst !== 32'h1000_0004) begin errors++; $display("[TB] FAIL slow_second got pc %h inst %h want 4 10000004", if_pc, if_inst); end
        cyc();
        checks++; if (fetch_count !== 32'd2) begin errors++; $display("[TB] FAIL slow_count2 got %0d want 2", fetch_count); end
    endtask

    task automatic test_stall();
        imem_ready = 1'b1;
        do_reset();
        cyc();
        cyc();
        cyc();
        id_stall = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_req_now got %0h want 0", imem_req); end
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++; if (if_pc !== 32'h0 || if_inst !== 32'h1000_0000 || if_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_hold%0d got pc %h inst %h v %0h", i, if_pc, if_inst, if_valid); end
            checks++; if (imem_req !== 1'b0 || fetch_count !== 32'd0) begin errors++; $display("[TB] FAIL stall_idle%0d got req %0h count %0d want 0 0", i, imem_req, fetch_count); end
        end
        id_stall = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("[TB] FAIL stall_release got req %0h addr %h want 1 4", imem_req, imem_addr); end
        cyc();
        checks++; if (if_pc !== 32'h4 || fetch_count !== 32'd1) begin errors++; $display("[TB] FAIL stall_after got pc %h count %0d want 4 1", if_pc, fetch_count); end
    endtask

    task automatic test_redirect_targets();
        imem_ready = 1'b1;
        do_reset();
        cyc();
        cyc();
        redir_valid = 1'b1; redir_kind = 2'b00; redir_pc_plus4 = 32'h0000_0100; redir_imm16 = 16'hFFFE;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL redir_req got %0h want 0", imem_req); end
        cyc();
        redir_valid = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h0000_00F8) begin errors++; $display("[TB] FAIL branch_target got %h want 000000f8", imem_addr); end
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL branch_flush got v %0h req %0h want 0 1", if_valid, imem_req); end
        cyc();
        checks++; if (if_pc !== 32'h0000_00F8) begin errors++; $display("[TB] FAIL branch_fetch got %h want 000000f8", if_pc); end
        redir_valid = 1'b1; redir_kind = 2'b01; redir_pc_plus4 = 32'hC000_0004; redir_index26 = 26'h0000040;
        cyc();
        redir_kind = 2'b10; redir_reg = 32'h0000_1237;
        checks++; if (imem_addr !== 32'hC000_0100) begin errors++; $display("[TB] FAIL jump_target got %h want c0000100", imem_addr); end
        checks++; if (fetch_count !== 32'd1) begin errors++; $display("[TB] FAIL redir_accept_count got %0d want 1", fetch_count); end
        cyc();
        checks++; if (imem_addr !== 32'h0000_1234) begin errors++; $display("[TB] FAIL jr_target got %h want 00001234", imem_addr); end
        redir_kind = 2'b11; redir_reg = 32'h0000_5555;
        cyc();
        checks++; if (imem_addr !== 32'h0000_1234) begin errors++; $display("[TB] FAIL rsvd_noop got %h want 00001234", imem_addr); end
        redir_kind = 2'b10; redir_reg = 32'hFFFF_FFFF;
        cyc();
        redir_valid = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL jr_top got %h want fffffffc", imem_addr); end
        cyc();
        checks++; if (if_pc !== 32'hFFFF_FFFC || if_pc_plus4 !== 32'h0) begin errors++; $display("[TB] FAIL wrap got pc %h pc4 %h want fffffffc 0", if_pc, if_pc_plus4); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_addr got %h want 0", imem_addr); end
    endtask

    task automatic test_redirect_stalled();
        imem_ready = 1'b1;
        do_reset();
        cyc();
        cyc();
        cyc();
        id_stall = 1'b1;
        cyc();
        redir_valid = 1'b1; redir_kind = 2'b01; redir_pc_plus4 = 32'h0000_0010; redir_index26 = 26'h0000100;
        cyc();
        redir_valid = 1'b0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL stalled_flush got %0h want 0", if_valid); end
        checks++; if (imem_addr !== 32'h0000_0400) begin errors++; $display("[TB] FAIL stalled_target got %h want 00000400", imem_addr); end
        checks++; if (fetch_count !== 32'd0) begin errors++; $display("[TB] FAIL stalled_count got %0d want 0", fetch_count); end
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL stalled_refetch got %0h want 1", imem_req); end
        id_stall = 1'b0;
        cyc();
        checks++; if (if_pc !== 32'h0000_0400 || if_inst !== 32'h1000_0400) begin errors++; $display("[TB] FAIL stalled_next got pc %h inst %h want 400 10000400", if_pc, if_inst); end
    endtask

    task automatic test_boot_redirect();
        imem_ready = 1'b1;
        do_reset();
        redir_valid = 1'b1; redir_kind = 2'b10; redir_reg = 32'h0000_0800;
        cyc();
        redir_valid = 1'b0;
        cyc();
        checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL boot_redir got addr %h req %0h want 0 1", imem_addr, imem_req); end
    endtask

    task automatic test_halt();
        imem_ready = 1'b1;
        halt_en = 1'b1;
        do_reset();
        cyc();
        cyc();
        for (int i = 0; i < 5; i++) cyc();
        checks++; if (if_inst !== 32'h0000_000C || if_pc !== 32'h10) begin errors++; $display("[TB] FAIL halt_word got inst %h pc %h want c 10", if_inst, if_pc); end
        checks++; if (halted !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL halt_state got halted %0h req %0h want 1 0", halted, imem_req); end
        checks++; if (fetch_count !== 32'd4) begin errors++; $display("[TB] FAIL halt_count4 got %0d want 4", fetch_count); end
        id_stall = 1'b1;
        cyc();
        checks++; if (if_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL halt_present got v %0h req %0h want 1 0", if_valid, imem_req); end
        id_stall = 1'b0;
        cyc();
        checks++; if (if_valid !== 1'b0 || fetch_count !== 32'd5) begin errors++; $display("[TB] FAIL halt_accept got v %0h count %0d want 0 5", if_valid, fetch_count); end
        cyc();
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0 || fetch_count !== 32'd5 || halted !== 1'b1) begin errors++; $display("[TB] FAIL halt_once got v %0h req %0h count %0d h %0h", if_valid, imem_req, fetch_count, halted); end
        redir_valid = 1'b1; redir_kind = 2'b10; redir_reg = 32'h0000_0200;
        cyc();
        redir_valid = 1'b0;
        #1;
        checks++; if (halted !== 1'b0 || imem_addr !== 32'h200 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL halt_exit got h %0h addr %h req %0h want 0 200 1", halted, imem_addr, imem_req); end
        cyc();
        rst = 1'b1;
        cyc();
        checks++; if (if_valid !== 1'b0 || if_inst !== 32'h0 || if_pc !== 32'h0 || if_pc_plus4 !== 32'h0) begin errors++; $display("[TB] FAIL rst_if got v %0h inst %h pc %h pc4 %h", if_valid, if_inst, if_pc, if_pc_plus4); end
        checks++; if (halted !== 1'b0 || fetch_count !== 32'd0 || imem_addr !== 32'h0 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_ctl got h %0h count %0d addr %h req %0h", halted, fetch_count, imem_addr, imem_req); end
        rst = 1'b0;
        halt_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_slow_memory();
        test_stall();
        test_redirect_targets();
        test_redirect_stalled();
        test_boot_redirect();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch front end of the single-issue MIPS datapath.
- Owns the program counter, drives the instruction-memory request/ready handshake, and registers fetched words for the decode stage.
- Accepts redirects from the downstream branch/jump logic and forms branch, jump and register targets with MIPS word-address arithmetic.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
BOOT_CYCLES, 2, idle cycles after reset before the first request (0 permitted)
HALT_INST, 32'h0000_000C, instruction word that stops further fetching

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  fetch request strobe
imem_addr  out  32  fetch address (equals pc)
imem_ready  in  1  memory returns imem_rdata this cycle for the current request
imem_rdata  in  32  fetched instruction word
if_valid  out  1  decode output register holds an instruction
if_inst  out  32  fetched instruction
if_pc  out  32  address of if_inst
if_pc_plus4  out  32  if_pc + 4
id_stall  in  1  decode cannot accept; if_* must hold
redir_valid  in  1  redirect request this cycle
redir_kind  in  2  00 branch, 01 jump, 10 jr, 11 reserved (ignored)
redir_pc_plus4  in  32  PC+4 of the redirecting instruction
redir_imm16  in  16  branch offset in words, signed
redir_index26  in  26  jump instruction index
redir_reg  in  32  jr register value
halted  out  1  in the HALTED state
fetch_count  out  32  instructions accepted by decode

Behaviour:
- Reset (rst=1 at an edge):
  - pc=RESET_PC; state=BOOT with boot counter=0 (or state=FETCH if BOOT_CYCLES=0).
  - if_valid=0, if_inst=0, if_pc=0, if_pc_plus4=0, halted=0, fetch_count=0.
  - imem_req=0 while rst is high.
- Reset mid-operation discards any pending fetch or redirect. A memory response arriving on the cycle after reset is ignored.
- Accept and free:
  - accept = if_valid & ~id_stall; fetch_count increments on accept and wraps at 2^32.
  - free = ~if_valid | ~id_stall.
- Targets:
  - branch = redir_pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00}, modulo 2^32.
  - jump = {redir_pc_plus4[31:28], index26, 2'b00}.
  - jr = {redir_reg[31:2], 2'b00}; the low bits are silently cleared.
- State BOOT:
  - imem_req=0; counter increments each cycle.
  - Go to FETCH in the cycle after the counter reaches BOOT_CYCLES-1.
- State FETCH:
  - imem_req = free & ~redir_valid; imem_addr=pc; imem_req may assert combinationally in the same cycle that decode frees the register.
  - On imem_req & imem_ready: next edge if_inst=imem_rdata, if_pc=pc, if_pc_plus4=pc+4, if_valid=1, pc=pc+4.
  - If that captured word equals HALT_INST, go to HALTED.
  - Zero-wait memory therefore sustains one instruction per cycle. Latency from request to if_valid is 1 cycle.
  - imem_req & ~imem_ready: hold the request with a stable address; no state change.
  - ~free: no request; if_* hold (this is the STALL condition, encoded as a state STALL entered when if_valid & id_stall, exited when ~id_stall).
  - A held request is withdrawn if decode stalls. Memory must tolerate request deassertion without ready.
- Redirect (kind != 11), any state except BOOT, highest priority:
  - Next edge pc=target and if_valid=0 (flush, even if id_stall); state=FETCH; halted=0.
  - imem_req=0 in the redirect cycle, so no capture occurs.
  - A simultaneous accept still counts in fetch_count.
  - redir_kind=11 is a no-op.
  - A redirect during BOOT is ignored.
- State HALTED:
  - halted=1, imem_req=0; the halt instruction remains presented until accepted, then if_valid=0.
  - Exits only by redirect or reset.
- pc+4 wraps 32'hFFFF_FFFC -> 0.

Decomposition:
- Shared package: redir_kind encodings, state encoding (BOOT, FETCH, STALL, HALTED), default RESET_PC and HALT_INST constants.
- Sub-module target_calc: combinational branch/jump/jr target selection. Reuses the existing sign-extend and shift-left-2 helpers.

Test Plan:
- Reset, BOOT_CYCLES=2, memory always ready -> imem_req first high in cycle 3 at addr 0; if_pc sequence 0,4,8 on consecutive cycles; fetch_count=3 after three accepts.
- Memory ready only every third cycle -> imem_addr stable while waiting; no duplicate or lost instruction; if_valid low between responses.
- if_valid=1 with id_stall held 4 cycles -> if_inst/if_pc unchanged, imem_req=0, fetch_count unchanged; release -> next fetch in the same cycle.
- Branch with redir_pc_plus4=32'h0000_0100, imm16=16'hFFFE -> pc=32'h0000_00F8; jump with pc_plus4=32'hC000_0004, index26=26'h0000040 -> pc=32'hC000_0100; jr with reg=32'h0000_1237 -> pc=32'h0000_1234.
- Redirect while if_valid & id_stall, with a pending ready -> if_valid=0 next cycle, response discarded, next imem_addr equals the target.
- Fetch of HALT_INST at 32'h10 -> halted=1, imem_req stays 0, halt word delivered once; rst asserted -> pc=RESET_PC, all outputs zero.
